// File: rtl/thread_ready_queue.sv
// Thread ready queue: round-robin pool of thread base addresses for a dispatcher.
// NEW messages fill the lowest free slot, END messages retire the last dispatched
// thread, and each exit from the dispatcher CPU-loop state advances to the next
// valid slot. Define THRD_STATS_EN to build the dispatch/drop statistics counters.
module thread_ready_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] RESET_PROC   = 32'h0,
    parameter logic [31:0] IDLE_PROC    = 32'hFFFF_FFFF,
    parameter logic [7:0]  CTL_LOOP     = 8'h02,
    parameter logic [7:0]  MSG_NEW_THRD = 8'h03,
    parameter logic [7:0]  MSG_END_THRD = 8'h04
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ctl_state,
    input  logic [7:0]               cpu_msg,
    input  logic [31:0]              msg_addr,
    output logic [31:0]              next_proc,
    output logic [31:0]              proc,
    output logic [$clog2(DEPTH):0]   thrd_count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              dispatch_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);
    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   cnt_t;

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    idx_t             cur_q, cur_d;
    idx_t             last_q, last_d;
    logic [31:0]      proc_q, proc_d;
    logic [31:0]      next_proc_q, next_proc_d;
    cnt_t             count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       prev_ctl_q;
    // Set when the current slot was retired; forces a scan on the next edge.
    logic             rescan_q, rescan_d;

    logic loop_exit, msg_new, msg_end, is_full, is_empty, drop;
    idx_t scan_idx, scan_cand, free_idx;
    logic scan_hit;

    // X/Z on the message bus compares unknown and so decodes as no message.
    assign msg_new   = (cpu_msg == MSG_NEW_THRD);
    assign msg_end   = (cpu_msg == MSG_END_THRD);
    assign loop_exit = (prev_ctl_q == CTL_LOOP) && (ctl_state != CTL_LOOP);
    assign is_full   = (count_q == cnt_t'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign drop      = msg_new && is_full;

    // Round-robin search for the next valid slot after cur_slot, ending on cur_slot.
    always_comb begin
        scan_idx  = cur_q;
        scan_cand = '0;
        scan_hit  = 1'b0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            scan_cand = idx_t'(cur_q + i);
            if (!scan_hit && valid_q[scan_cand]) begin
                scan_idx = scan_cand;
                scan_hit = 1'b1;
            end
        end
    end

    // Lowest-index free slot for an incoming thread.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = idx_t'(i);
        end
    end

    // Next-state: dispatch on loop exit, then apply the message of this cycle.
    always_comb begin
        addr_d      = addr_q;
        valid_d     = valid_q;
        cur_d       = cur_q;
        last_d      = last_q;
        proc_d      = proc_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        rescan_d    = 1'b0;
        next_proc_d = next_proc_q;
        // Frozen while the dispatcher sits in its loop so it sees a stable target.
        if (ctl_state != CTL_LOOP) begin
            next_proc_d = is_empty ? IDLE_PROC : addr_q[cur_q];
        end
        if (loop_exit) begin
            last_d = cur_q;
            proc_d = addr_q[cur_q];
        end
        // Scan sees pre-edge valid bits, so a slot filled this edge is skipped.
        if (loop_exit || rescan_q) begin
            cur_d = scan_idx;
        end
        if (msg_new) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                addr_d[free_idx]  = msg_addr;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + 1'b1;
                if (is_empty) cur_d = free_idx;
            end
        end else if (msg_end && valid_q[last_q]) begin
            valid_d[last_q] = 1'b0;
            count_d         = count_q - 1'b1;
            rescan_d        = (cur_d == last_q);
        end
    end

    // State registers with synchronous reset to the single boot thread.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= (i == 0) ? RESET_PROC : 32'h0;
            end
            valid_q     <= {{(DEPTH-1){1'b0}}, 1'b1};
            cur_q       <= '0;
            last_q      <= '0;
            proc_q      <= RESET_PROC;
            next_proc_q <= RESET_PROC;
            count_q     <= cnt_t'(1);
            overflow_q  <= 1'b0;
            prev_ctl_q  <= 8'h0;
            rescan_q    <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            proc_q      <= proc_d;
            next_proc_q <= next_proc_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            prev_ctl_q  <= ctl_state;
            rescan_q    <= rescan_d;
        end
    end

    assign next_proc  = next_proc_q;
    assign proc       = proc_q;
    assign thrd_count = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = overflow_q;

`ifdef THRD_STATS_EN
    logic [15:0] dispatch_q;
    logic [7:0]  drop_q;

    // Dispatch counter wraps; drop counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_q <= '0;
            drop_q     <= '0;
        end else begin
            if (loop_exit) dispatch_q <= dispatch_q + 16'd1;
            if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

    assign dispatch_cnt = dispatch_q;
    assign drop_cnt     = drop_q;
`else
    logic unused_drop;
    assign unused_drop  = drop;
    assign dispatch_cnt = '0;
    assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_thread_ready_queue.sv
// Directed bench for thread_ready_queue: vector table plus hand-written sequences.
module tb_thread_ready_queue;

    localparam logic [7:0] C0 = 8'h00;
    localparam logic [7:0] CL = 8'h02;
    localparam logic [7:0] MN = 8'h03;
    localparam logic [7:0] ME = 8'h04;
`ifdef THRD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ctl_state = 8'h0;
    logic [7:0]  cpu_msg = 8'h0;
    logic [31:0] msg_addr = 32'h0;
    logic [31:0] next_proc, proc;
    logic [3:0]  thrd_count;
    logic        empty, full, overflow;
    logic [15:0] dispatch_cnt;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    thread_ready_queue dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_state    (ctl_state),
        .cpu_msg      (cpu_msg),
        .msg_addr     (msg_addr),
        .next_proc    (next_proc),
        .proc         (proc),
        .thrd_count   (thrd_count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .dispatch_cnt (dispatch_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctl;
        logic [7:0]  msg;
        logic [31:0] addr;
        logic [31:0] e_proc;
        logic [31:0] e_next;
        int          e_count;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] ctl, input logic [7:0] msg, input logic [31:0] addr,
                       input logic [31:0] e_proc, input logic [31:0] e_next,
                       input int e_count, input logic e_ovf);
        vec_t v;
        v.ctl = ctl; v.msg = msg; v.addr = addr;
        v.e_proc = e_proc; v.e_next = e_next; v.e_count = e_count; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic [7:0] ctl, input logic [7:0] msg, input logic [31:0] addr);
        @(negedge clk);
        rst = 1'b0; ctl_state = ctl; cpu_msg = msg; msg_addr = addr;
        @(posedge clk);
        #1;
    endtask

    // Loop entry, loop exit, then one settle cycle so next_proc reflects the new slot.
    task automatic visit();
        cyc(CL, 8'h0, 32'h0);
        cyc(C0, 8'h0, 32'h0);
        cyc(C0, 8'h0, 32'h0);
    endtask

    task automatic chk_state(input string pfx, input logic [31:0] e_proc,
                             input logic [31:0] e_next, input int e_count, input logic e_ovf);
        chk({pfx, " proc"}, proc, e_proc);
        chk({pfx, " next_proc"}, next_proc, e_next);
        chk({pfx, " thrd_count"}, 32'(thrd_count), 32'(e_count));
        chk({pfx, " empty"}, 32'(empty), 32'(e_count == 0));
        chk({pfx, " full"}, 32'(full), 32'(e_count == 8));
        chk({pfx, " overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    logic [31:0] exp_seq [8];

    initial begin
        // Main sequence: two threads, round robin, retire, empty, refill, overflow.
        add(C0, MN, 32'h10, 32'h0,  32'h0,  2, 1'b0);
        add(C0, MN, 32'h20, 32'h0,  32'h0,  3, 1'b0);
        add(CL, C0, 32'h0,  32'h0,  32'h0,  3, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h0,  3, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h10, 3, 1'b0);
        add(CL, C0, 32'h0,  32'h0,  32'h10, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h10, 32'h10, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h10, 32'h20, 3, 1'b0);
        add(CL, C0, 32'h0,  32'h10, 32'h20, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h20, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h0,  3, 1'b0);
        add(CL, C0, 32'h0,  32'h20, 32'h0,  3, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h0,  3, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h10, 3, 1'b0);
        add(CL, C0, 32'h0,  32'h0,  32'h10, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h10, 32'h10, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h10, 32'h20, 3, 1'b0);
        add(C0, ME, 32'h0,  32'h10, 32'h20, 2, 1'b0);
        add(CL, C0, 32'h0,  32'h10, 32'h20, 2, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h20, 2, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h0,  2, 1'b0);
        add(CL, C0, 32'h0,  32'h20, 32'h0,  2, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h0,  2, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h20, 2, 1'b0);
        add(CL, C0, 32'h0,  32'h0,  32'h20, 2, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h20, 2, 1'b0);
        add(C0, C0, 32'h0,  32'h20, 32'h0,  2, 1'b0);
        add(C0, ME, 32'h0,  32'h20, 32'h0,  1, 1'b0);
        add(CL, C0, 32'h0,  32'h20, 32'h0,  1, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h0,  1, 1'b0);
        add(C0, ME, 32'h0,  32'h0,  32'h0,  0, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'hFFFF_FFFF, 0, 1'b0);
        add(C0, ME, 32'h0,  32'h0,  32'hFFFF_FFFF, 0, 1'b0);
        add(C0, MN, 32'h40, 32'h0,  32'hFFFF_FFFF, 1, 1'b0);
        add(C0, C0, 32'h0,  32'h0,  32'h40, 1, 1'b0);
        add(C0, MN, 32'h50, 32'h0,  32'h40, 2, 1'b0);
        add(CL, C0, 32'h0,  32'h0,  32'h40, 2, 1'b0);
        add(C0, MN, 32'h30, 32'h40, 32'h40, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h40, 32'h50, 3, 1'b0);
        add(CL, C0, 32'h0,  32'h40, 32'h50, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h50, 32'h50, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h50, 32'h30, 3, 1'b0);
        add(CL, C0, 32'h0,  32'h50, 32'h30, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h30, 32'h30, 3, 1'b0);
        add(C0, C0, 32'h0,  32'h30, 32'h40, 3, 1'b0);
        add(C0, MN, 32'h61, 32'h30, 32'h40, 4, 1'b0);
        add(C0, MN, 32'h62, 32'h30, 32'h40, 5, 1'b0);
        add(C0, MN, 32'h63, 32'h30, 32'h40, 6, 1'b0);
        add(C0, MN, 32'h64, 32'h30, 32'h40, 7, 1'b0);
        add(C0, MN, 32'h65, 32'h30, 32'h40, 8, 1'b0);
        add(C0, MN, 32'h99, 32'h30, 32'h40, 8, 1'b1);

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 32'h0, 32'h0, 1, 1'b0);
        chk("reset dispatch_cnt", 32'(dispatch_cnt), 32'h0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'h0);

        // Single boot thread is re-selected on every visit.
        for (int v = 0; v < 3; v++) begin
            visit();
            chk_state($sformatf("boot visit%0d", v), 32'h0, 32'h0, 1, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].ctl, tbl[i].msg, tbl[i].addr);
            chk_state($sformatf("row%0d", i + 1), tbl[i].e_proc, tbl[i].e_next,
                      tbl[i].e_count, tbl[i].e_ovf);
        end
        chk("table dispatch_cnt", 32'(dispatch_cnt), STATS ? 32'd15 : 32'd0);
        chk("table drop_cnt", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);

        // Full queue: one lap must visit every slot exactly in order, never the dropped 0x99.
        exp_seq[0] = 32'h40; exp_seq[1] = 32'h50; exp_seq[2] = 32'h30; exp_seq[3] = 32'h61;
        exp_seq[4] = 32'h62; exp_seq[5] = 32'h63; exp_seq[6] = 32'h64; exp_seq[7] = 32'h65;
        for (int v = 0; v < 8; v++) begin
            visit();
            chk($sformatf("lap%0d proc", v), proc, exp_seq[v]);
            chk($sformatf("lap%0d next_proc", v), next_proc, exp_seq[(v + 1) % 8]);
        end
        chk("lap dispatch_cnt", 32'(dispatch_cnt), STATS ? 32'd23 : 32'd0);

        // Reset mid-operation with a NEW pending and loop state active.
        @(negedge clk);
        rst = 1'b1; ctl_state = CL; cpu_msg = MN; msg_addr = 32'h77;
        @(posedge clk);
        #1;
        chk_state("midrst", 32'h0, 32'h0, 1, 1'b0);
        chk("midrst dispatch_cnt", 32'(dispatch_cnt), 32'h0);
        chk("midrst drop_cnt", 32'(drop_cnt), 32'h0);
        cyc(C0, C0, 32'h0);
        chk_state("postrst", 32'h0, 32'h0, 1, 1'b0);
        visit();
        chk_state("postrst visit", 32'h0, 32'h0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/thread_ready_queue.md
THREAD_READY_QUEUE -- requirements
Module: thread_ready_queue

Interface
REQ-001 Parameter: DEPTH, 8, number of thread slots (power of two, 2..32).
REQ-002 Parameter: RESET_PROC, 32'h0, base address loaded into slot 0 at reset.
REQ-003 Parameter: IDLE_PROC, 32'hFFFFFFFF, next_proc value when no slot is valid.
REQ-004 Parameter: CTL_LOOP, 8'h02, ctl_state code of the dispatcher CPU-loop state.
REQ-005 Parameter: MSG_NEW_THRD, 8'h03 / MSG_END_THRD, 8'h04, cpu_msg codes.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ctl_state  input  8  dispatcher state code.
REQ-009 cpu_msg  input  8  inter-CPU message bus; values containing x/z match no code.
REQ-010 msg_addr  input  32  thread base address accompanying MSG_NEW_THRD.
REQ-011 next_proc  output  32  registered address of the thread to dispatch next.
REQ-012 proc  output  32  registered address of the most recently dispatched thread.
REQ-013 thrd_count  output  $clog2(DEPTH)+1  number of valid slots.
REQ-014 empty / full  output  1 each  thrd_count==0 / thrd_count==DEPTH.
REQ-015 overflow  output  1  sticky; a MSG_NEW_THRD arrived while full.
REQ-016 dispatch_cnt  output  16  / drop_cnt  output  8  statistics (REQ-036).

Function
REQ-017 Storage: DEPTH x 32 address array plus one valid bit per slot; cur_slot and last_slot pointers.
REQ-018 Loop exit: a cycle with prev_ctl==CTL_LOOP and ctl_state!=CTL_LOOP.
REQ-019 On loop exit: last_slot<=cur_slot; proc<=addr[cur_slot]; cur_slot<=first valid slot scanning cur_slot+1, cur_slot+2, ... mod DEPTH, ending with cur_slot itself.
REQ-020 next_proc SHALL equal addr[cur_slot] one cycle after any change to cur_slot or its contents; IDLE_PROC when empty.
REQ-021 next_proc SHALL stay stable for the whole time ctl_state==CTL_LOOP.
REQ-022 MSG_NEW_THRD, not full: lowest-index invalid slot <= msg_addr, valid set, thrd_count+1.
REQ-023 MSG_NEW_THRD while full: message dropped, overflow<=1, no other state change.
REQ-024 MSG_NEW_THRD while empty: new slot becomes cur_slot; next_proc = msg_addr on the following cycle.
REQ-025 MSG_END_THRD: clear valid[last_slot] if set, thrd_count-1; ignored if already clear.
REQ-026 If the slot cleared by REQ-025 equals cur_slot: cur_slot re-scanned per REQ-019 on the next edge.
REQ-027 Simultaneous loop exit and message: scan uses pre-edge valid bits; the message is applied in the same edge; a slot filled in that edge is not selectable until the next scan.
REQ-028 Message codes are level-decoded once per cycle; the sender holds a code for exactly one cycle.
REQ-029 Wrap-around: scan past slot DEPTH-1 continues at slot 0; a single valid slot is re-selected indefinitely.
REQ-030 thrd_count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-031 On rst: valid = only slot 0; addr[0] = RESET_PROC; other addr = 0.
REQ-032 On rst: cur_slot = last_slot = 0; next_proc = proc = RESET_PROC; thrd_count = 1; overflow = 0; prev_ctl = 0.
REQ-033 Reset asserted mid-operation discards all slots and pending messages in the same edge.
REQ-034 rst has priority over every other input.

Configuration
REQ-035 Macro THRD_STATS_EN compiles the statistics counters in or out.
REQ-036 Defined: dispatch_cnt +1 per loop exit (wraps at 16'hFFFF); drop_cnt +1 per REQ-023 drop (saturates at 8'hFF); both 0 at reset.
REQ-037 Undefined: dispatch_cnt and drop_cnt ports remain present and are driven constant 0; no counter logic is generated.

Verification
REQ-038 Reset, then 3 loop visits -> next_proc=0 throughout, thrd_count=1, proc=0.
REQ-039 NEW 0x10, NEW 0x20; 4 loop exits -> proc sequence 0x0, 0x10, 0x20, 0x0; next_proc leads proc by one visit.
REQ-040 Fill to 8 slots, NEW 0x99 -> full=1, overflow=1, drop_cnt=1 (THRD_STATS_EN); no slot holds 0x99.
REQ-041 Dispatch 0x10, then END -> thrd_count-1, 0x10 never reappears; END with only slot 0 valid -> empty=1, next_proc=0xFFFFFFFF.
REQ-042 Loop exit and NEW 0x30 in the same cycle -> scan ignores 0x30, next visit selects it; rst mid-sequence -> REQ-032 values next cycle.
